fsm_prog_loader: RTL and testbench

- Programming sequencer for the programmable FSM controller.
- Takes a framed byte stream from the host over a valid/ready handshake.
- Drives the controller's programming interface (prog_enable, prog_advance, prog_data) one table byte at a time, then verifies an XOR checksum.
- Reports busy/done/error status. Sits between the host input pins and the controller's programming port.

---
 rtl/fsm_prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_fsm_prog_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_prog_loader.sv
// rtl/fsm_prog_loader.sv - framed byte-stream loader for the programmable FSM controller table
//
// Purpose:
//   Accepts a host frame of the form SYNC_BYTE, TABLE_BYTES table bytes, and one
//   XOR checksum byte. Each table byte is presented on prog_data and committed
//   with a one-cycle prog_advance strobe. Once the whole table is written, the
//   checksum byte is compared against the running XOR. Outcome is reported
//   through sticky done/error flags.
//
// Ports:
//   clock        rising-edge clock
//   rst          synchronous reset, active high
//   in_valid     host byte valid
//   in_data      host byte
//   in_ready     loader accepts in_data this cycle (combinational: state, abort)
//   abort        cancel current frame (level)
//   prog_enable  controller programming mode
//   prog_advance one-cycle write strobe for prog_data
//   prog_data    table byte to the controller
//   busy         frame in progress (LOAD, STROBE or CHECK)
//   done         sticky: last frame loaded and checksum matched
//   error        sticky: 0 none, 1 timeout, 2 checksum mismatch, 3 aborted
//   byte_count   table bytes written in the current/last frame

module fsm_prog_loader #(
  parameter int         TABLE_BYTES = 128,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT     = 1024
) (
  input  logic                               clock,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  input  logic                               abort,
  output logic                               prog_enable,
  output logic                               prog_advance,
  output logic [7:0]                         prog_data,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         error,
  output logic [$clog2(TABLE_BYTES+1)-1:0]   byte_count
);

  localparam int CW = $clog2(TABLE_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_CHECK
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      checksum;
  logic [TW-1:0]   idle_cnt;
  logic            adv_q;
  logic            accept;
  logic            waiting;
  logic            timed_out;
  logic            table_full;

  assign accept     = in_valid & in_ready;
  assign waiting    = (state == S_LOAD) || (state == S_CHECK);
  // Abort outranks timeout, so a timeout is only recognised with abort low.
  assign timed_out  = waiting && !accept && !abort && (idle_cnt == TW'(TIMEOUT - 1));
  assign table_full = (byte_count == CW'(TABLE_BYTES));

  // State register
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (abort)          next_state = S_IDLE;
        else if (accept)    next_state = S_STROBE;
        else if (timed_out) next_state = S_IDLE;
      end
      S_STROBE: begin
        if (abort)           next_state = S_IDLE;
        else if (table_full) next_state = S_CHECK;
        else                 next_state = S_LOAD;
      end
      S_CHECK: begin
        if (abort)          next_state = S_IDLE;
        else if (accept)    next_state = S_IDLE;
        else if (timed_out) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic. The strobe register is decoded from next_state so it is
  // high during STROBE; an abort in that same cycle must still cancel the
  // write, hence the late gating with abort.
  always_comb begin
    in_ready     = !abort && (state != S_STROBE);
    prog_advance = adv_q && !abort;
  end

  // Registered mode outputs, decoded one cycle ahead from next_state
  always_ff @(posedge clock) begin
    if (rst) begin
      prog_enable <= 1'b0;
      busy        <= 1'b0;
      adv_q       <= 1'b0;
    end else begin
      prog_enable <= (next_state != S_IDLE);
      busy        <= (next_state != S_IDLE);
      adv_q       <= (next_state == S_STROBE);
    end
  end

  // Datapath: table byte, running checksum, counters and sticky status
  always_ff @(posedge clock) begin
    if (rst) begin
      prog_data  <= '0;
      checksum   <= '0;
      byte_count <= '0;
      idle_cnt   <= '0;
      done       <= 1'b0;
      error      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            done       <= 1'b0;
            error      <= '0;
            byte_count <= '0;
            checksum   <= '0;
            idle_cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            error <= ERR_ABORT;
          end else if (accept) begin
            prog_data  <= in_data;
            checksum   <= checksum ^ in_data;
            byte_count <= byte_count + CW'(1);
            idle_cnt   <= '0;
          end else if (timed_out) begin
            error <= ERR_TIMEOUT;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_STROBE: begin
          // idle counter frozen here
          if (abort) error <= ERR_ABORT;
        end
        S_CHECK: begin
          if (abort) begin
            error <= ERR_ABORT;
          end else if (accept) begin
            idle_cnt <= '0;
            if (in_data == checksum) done  <= 1'b1;
            else                     error <= ERR_CHECKSUM;
          end else if (timed_out) begin
            error <= ERR_TIMEOUT;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_prog_loader.sv
// tb/tb_fsm_prog_loader.sv - directed self-checking bench for fsm_prog_loader

module tb_fsm_prog_loader;

  logic       clock = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       abort;
  logic       prog_enable;
  logic       prog_advance;
  logic [7:0] prog_data;
  logic       busy;
  logic       done;
  logic [1:0] error;
  logic [2:0] byte_count;

  int total = 0;
  int bad   = 0;
  int strobes = 0;

  fsm_prog_loader #(
    .TABLE_BYTES(4),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT    (16)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .abort       (abort),
    .prog_enable (prog_enable),
    .prog_advance(prog_advance),
    .prog_data   (prog_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .byte_count  (byte_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (prog_advance) strobes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge; returns just after a posedge.
  // Data bytes also verify the strobe cycle that follows the accept.
  task automatic send(input logic [7:0] b, input bit is_data);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    check("rdy", 32'(in_ready), 1);
    @(posedge clock); #1;
    if (is_data) begin
      @(negedge clock);
      check("strobe_adv", 32'(prog_advance), 1);
      check("strobe_rdy", 32'(in_ready), 0);
      check("strobe_data", 32'(prog_data), 32'(b));
      check("strobe_pe", 32'(prog_enable), 1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("idle_rdy", 32'(in_ready), 1);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int s0;
    logic [7:0] cs;
    logic [7:0] d;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_rdy", 32'(in_ready), 1);
    check("rst_pe", 32'(prog_enable), 0);
    check("rst_adv", 32'(prog_advance), 0);
    check("rst_data", 32'(prog_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    check("rst_bc", 32'(byte_count), 0);
    @(posedge clock); #1;

    // Nominal frame: checksum 01^02^03^04 = 04
    s0 = strobes;
    send(8'hA5, 0);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    @(negedge clock);
    check("nom_check_pe", 32'(prog_enable), 1);
    check("nom_check_busy", 32'(busy), 1);
    @(posedge clock); #1;
    send(8'h04, 0);
    @(negedge clock);
    check("nom_done", 32'(done), 1);
    check("nom_err", 32'(error), 0);
    check("nom_bc", 32'(byte_count), 4);
    check("nom_pe", 32'(prog_enable), 0);
    check("nom_busy", 32'(busy), 0);
    check("nom_strobes", 32'(strobes - s0), 4);
    @(posedge clock); #1;

    // Bad checksum
    s0 = strobes;
    send(8'hA5, 0);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    send(8'h05, 0);
    @(negedge clock);
    check("bad_err", 32'(error), 2);
    check("bad_done", 32'(done), 0);
    check("bad_strobes", 32'(strobes - s0), 4);
    @(posedge clock); #1;
    send(8'hA5, 0);
    @(negedge clock);
    check("resync_err", 32'(error), 0);
    check("resync_busy", 32'(busy), 1);
    @(posedge clock); #1;
    // abort in LOAD leaves the frame with error 3
    abort = 1'b1;
    @(negedge clock);
    check("abort_load_rdy", 32'(in_ready), 0);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_load_err", 32'(error), 3);
    check("abort_load_busy", 32'(busy), 0);
    @(posedge clock); #1;

    // Abort in IDLE blocks acceptance, even of SYNC
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clock);
    check("idle_abort_rdy", 32'(in_ready), 0);
    @(posedge clock); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("idle_abort_busy", 32'(busy), 0);
    check("idle_abort_err", 32'(error), 3);
    @(posedge clock); #1;

    // Garbage before sync, then a valid frame
    s0 = strobes;
    send(8'h00, 0);
    @(negedge clock);
    check("garb_pe0", 32'(prog_enable), 0);
    @(posedge clock); #1;
    send(8'hFF, 0);
    send(8'h3C, 0);
    @(negedge clock);
    check("garb_pe", 32'(prog_enable), 0);
    check("garb_err_kept", 32'(error), 3);
    check("garb_strobes", 32'(strobes - s0), 0);
    @(posedge clock); #1;
    send(8'hA5, 0);
    send(8'h10, 1); send(8'h20, 1); send(8'hA5, 1); send(8'h01, 1);
    send(8'h94, 0);  // 10^20^A5^01 = 94
    @(negedge clock);
    check("garb_done", 32'(done), 1);
    check("garb_err", 32'(error), 0);
    check("garb_strobes2", 32'(strobes - s0), 4);
    @(posedge clock); #1;

    // Timeout after one data byte
    send(8'hA5, 0);
    send(8'h11, 1);
    idle(15);
    @(negedge clock);
    check("to_pre_busy", 32'(busy), 1);
    check("to_pre_err", 32'(error), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("to_err", 32'(error), 1);
    check("to_busy", 32'(busy), 0);
    check("to_pe", 32'(prog_enable), 0);
    check("to_bc", 32'(byte_count), 1);
    @(posedge clock); #1;
    idle(4);

    // Abort during the second strobe
    s0 = strobes;
    send(8'hA5, 0);
    send(8'h01, 1);
    send(8'h02, 0);  // accepted; now in STROBE
    abort = 1'b1;
    @(negedge clock);
    check("ab_adv", 32'(prog_advance), 0);
    check("ab_rdy", 32'(in_ready), 0);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("ab_err", 32'(error), 3);
    check("ab_busy", 32'(busy), 0);
    check("ab_pe", 32'(prog_enable), 0);
    check("ab_strobes", 32'(strobes - s0), 1);
    @(posedge clock); #1;

    // rst mid-frame
    send(8'hA5, 0);
    send(8'h33, 1);
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("mrst_pe", 32'(prog_enable), 0);
    check("mrst_adv", 32'(prog_advance), 0);
    check("mrst_data", 32'(prog_data), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_err", 32'(error), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_bc", 32'(byte_count), 0);
    check("mrst_rdy", 32'(in_ready), 1);
    @(posedge clock); #1;

    // Backpressure: random gaps shorter than TIMEOUT
    s0 = strobes;
    cs = 8'h00;
    send(8'hA5, 0);
    for (int k = 0; k < 4; k++) begin
      idle(int'($urandom_range(0, 10)));
      d = 8'($urandom_range(0, 255));
      cs = cs ^ d;
      send(d, 1);
    end
    idle(int'($urandom_range(0, 10)));
    send(cs, 0);
    @(negedge clock);
    check("bp_done", 32'(done), 1);
    check("bp_err", 32'(error), 0);
    check("bp_bc", 32'(byte_count), 4);
    check("bp_strobes", 32'(strobes - s0), 4);
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
